frame_load_ctrl: RTL and testbench

- Host-link frame sequencer between the UART receiver and the accelerator's weight/input buffers and compute core.
- Parses a one-byte header, then packs payload bytes into 64-bit words and issues buffer writes with auto-incrementing addresses.
- Can instead fire a compute start and hold busy until the core reports done.
- Polices inter-byte timeout, illegal opcodes and overrun, reporting each with an error pulse and code.

---
 rtl/frame_load_ctrl_pkg.sv | 27 ++
 rtl/frame_load_ctrl_if.sv | 28 ++
 rtl/frame_load_ctrl_word_packer.sv | 46 ++++
 rtl/frame_load_ctrl.sv | 161 ++++++++++++++++
 tb/tb_frame_load_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_load_ctrl_pkg.sv
// Shared types and constants for the host-link frame sequencer.
// Opcode, FSM state and error-code encodings used by the controller and its bench.
package tfe_ctrl_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;

  typedef enum logic [1:0] {
    OP_LDW = 2'b00,
    OP_LDI = 2'b01,
    OP_RUN = 2'b10,
    OP_BAD = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PAYLOAD = 2'b01,
    RUN     = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_TIMEOUT  = 2'b01,
    ERR_OPCODE   = 2'b10,
    ERR_OVERRUN  = 2'b11
  } err_code_e;

endpackage

// File: rtl/frame_load_ctrl_if.sv
// Byte-in / buffer-write-out bus of the frame sequencer.
// The controller takes the slave side; the UART/buffer environment takes master.
interface frame_load_ctrl_if #(
  parameter int unsigned ADDR_W = 6
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic              core_done;
  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              frame_done;
  logic              start;
  logic              busy;
  logic              err;
  logic [1:0]        err_code;

  modport master (
    output rx_byte, rx_valid, core_done,
    input  wr_en, wr_sel, wr_addr, wr_data, frame_done, start, busy, err, err_code
  );

  modport slave (
    input  rx_byte, rx_valid, core_done,
    output wr_en, wr_sel, wr_addr, wr_data, frame_done, start, busy, err, err_code
  );
endinterface

// File: rtl/frame_load_ctrl_word_packer.sv
// Packs bytes LSB-first into a 64-bit word; word_ready_o flags the byte that completes it.
// word_o is the word including the current byte, so the caller can register it in one step.
module word_packer
  import tfe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  byte_i,
  output logic [63:0] word_o,
  output logic        word_ready_o
);

  localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     acc_q, acc_d;

  // Shift right so the first byte ends up in [7:0] after eight bytes.
  assign word_o       = {byte_i, acc_q[63:8]};
  assign word_ready_o = valid_i && !clear_i && (cnt_q == CntW'(BYTES_PER_WORD - 1));

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (valid_i) begin
      acc_d = word_o;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/frame_load_ctrl.sv
// Host-link frame sequencer: header decode, payload packing into buffer writes,
// compute start/busy tracking, and timeout/opcode/overrun error reporting.
module frame_load_ctrl
  import tfe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  frame_load_ctrl_if.slave bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [63:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  err_code_e         err_code_q, err_code_d;

  logic              pack_clear;
  logic [63:0]       pack_word;
  logic              pack_ready;

  word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pack_clear),
    .valid_i      (bus.rx_valid && (state_q == PAYLOAD)),
    .byte_i       (bus.rx_byte),
    .word_o       (pack_word),
    .word_ready_o (pack_ready)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    count_d      = count_q;
    word_cnt_d   = word_cnt_q;
    tmo_d        = tmo_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    start_d      = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    pack_clear   = 1'b0;
    // Address advances the cycle after each write so wr_addr is stable during wr_en.
    wr_addr_d    = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.rx_valid) begin
          unique case (opcode_e'(bus.rx_byte[7:6]))
            OP_LDW, OP_LDI: begin
              sel_d      = bus.rx_byte[6];
              count_d    = bus.rx_byte[ADDR_W-1:0];
              word_cnt_d = '0;
              wr_addr_d  = '0;
              tmo_d      = '0;
              pack_clear = 1'b1;
              state_d    = PAYLOAD;
            end
            OP_RUN: begin
              start_d = 1'b1;
              state_d = RUN;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = ERR_OPCODE;
            end
          endcase
        end
      end

      PAYLOAD: begin
        if (bus.rx_valid) begin
          tmo_d = '0;
          if (pack_ready) begin
            wr_en_d    = 1'b1;
            wr_data_d  = pack_word;
            word_cnt_d = word_cnt_q + 1'b1;
            if (word_cnt_q == count_q) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end
          end
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          tmo_d      = '0;
          pack_clear = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      RUN: begin
        if (bus.rx_valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (bus.core_done) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      count_q      <= '0;
      word_cnt_q   <= '0;
      tmo_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      count_q      <= count_d;
      word_cnt_q   <= word_cnt_d;
      tmo_q        <= tmo_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      start_q      <= start_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_sel     = sel_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.start      = start_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Randomized bench for frame_load_ctrl: frames are described at transaction level and the
// expected writes/errors/starts are derived from the frame contents, then matched to a monitor.
module tb_frame_load_ctrl;
  import tfe_ctrl_pkg::*;

  localparam int unsigned AW  = 6;
  localparam int unsigned TMO = 40;
  localparam int          OBS = 4096;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [63:0]   data;
    logic          last;
  } wr_ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  frame_load_ctrl_if #(.ADDR_W(AW)) bus ();

  frame_load_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: only this process writes the observation records.
  wr_ev_t     obs_wr  [OBS];
  logic [1:0] obs_err [OBS];
  int obs_wr_n = 0, obs_err_n = 0, obs_start_n = 0, busy_cyc = 0, onehot_bad = 0, stray_done = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        obs_wr[obs_wr_n % OBS] = '{sel: bus.wr_sel, addr: bus.wr_addr, data: bus.wr_data,
                                   last: bus.frame_done};
        obs_wr_n++;
      end
      if (bus.frame_done && !bus.wr_en) stray_done++;
      if (bus.err) begin
        obs_err[obs_err_n % OBS] = bus.err_code;
        obs_err_n++;
      end
      if (bus.start) obs_start_n++;
      if (bus.busy) busy_cyc++;
      if (int'(bus.wr_en) + int'(bus.start) + int'(bus.err) > 1) onehot_bad++;
    end
  end

  // Expectations, written only by the stimulus process.
  wr_ev_t        exp_wr [$];
  logic [1:0]    exp_err[$];
  logic [7:0]    pay_q  [$];
  int            exp_start = 0, exp_busy = -1;
  int            wr_rd = 0, err_rd = 0, start_rd = 0, busy_rd = 0;
  logic [63:0]   last_data = '0;
  logic [1:0]    last_err  = '0;
  logic [AW-1:0] exp_addr  = '0;
  logic          exp_sel   = 1'b0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'($urandom);
  endtask

  task automatic fill_rand(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 3));
    if (r == 8) return TMO - 1;
    return 0;
  endfunction

  task automatic compare(input string tag);
    int     nw, ne;
    wr_ev_t o, e;
    tick(3);
    nw = obs_wr_n - wr_rd;
    ne = obs_err_n - err_rd;
    check_eq($sformatf("%s wr_count", tag), 64'(nw), 64'(exp_wr.size()));
    for (int i = 0; i < nw && i < exp_wr.size(); i++) begin
      o = obs_wr[(wr_rd + i) % OBS];
      e = exp_wr[i];
      check_eq($sformatf("%s wr%0d data", tag, i), o.data, e.data);
      check_eq($sformatf("%s wr%0d sel/addr/last", tag, i), 64'({o.sel, o.addr, o.last}),
               64'({e.sel, e.addr, e.last}));
    end
    check_eq($sformatf("%s err_count", tag), 64'(ne), 64'(exp_err.size()));
    for (int i = 0; i < ne && i < exp_err.size(); i++)
      check_eq($sformatf("%s err%0d code", tag, i), 64'(obs_err[(err_rd + i) % OBS]),
               64'(exp_err[i]));
    check_eq($sformatf("%s start_count", tag), 64'(obs_start_n - start_rd), 64'(exp_start));
    if (exp_busy >= 0)
      check_eq($sformatf("%s busy_cycles", tag), 64'(busy_cyc - busy_rd), 64'(exp_busy));
    if (exp_wr.size() > 0) last_data = exp_wr[$].data;
    if (exp_err.size() > 0) last_err = exp_err[$];
    check_eq($sformatf("%s busy_idle", tag), 64'(bus.busy), 64'(0));
    check_eq($sformatf("%s wr_data_hold", tag), bus.wr_data, last_data);
    check_eq($sformatf("%s err_code_hold", tag), 64'(bus.err_code), 64'(last_err));
    check_eq($sformatf("%s wr_addr", tag), 64'(bus.wr_addr), 64'(exp_addr));
    check_eq($sformatf("%s wr_sel", tag), 64'(bus.wr_sel), 64'(exp_sel));
    wr_rd    = obs_wr_n;
    err_rd   = obs_err_n;
    start_rd = obs_start_n;
    busy_rd  = busy_cyc;
    exp_wr.delete();
    exp_err.delete();
    exp_start = 0;
    exp_busy  = -1;
  endtask

  // Load frame of cnt+1 words; sending fewer bytes than the frame needs provokes a timeout.
  task automatic do_load(input string tag, input logic [1:0] op, input int cnt, input int nsend,
                         input bit rand_gap);
    int          nfull, total;
    logic [63:0] d;
    total = cnt + 1;
    send({op, 6'(cnt)});
    for (int i = 0; i < nsend; i++) begin
      if (rand_gap) tick(pick_gap());
      send(pay_q[i]);
    end
    nfull = nsend / BYTES_PER_WORD;
    for (int w = 0; w < nfull; w++) begin
      d = '0;
      for (int k = 0; k < 8; k++) d = d | (64'(pay_q[8 * w + k]) << (8 * k));
      exp_wr.push_back('{sel: op[0], addr: AW'(w), data: d, last: (w == total - 1)});
    end
    if (nsend < 8 * total) begin
      tick(TMO + 2);
      exp_err.push_back(2'(ERR_TIMEOUT));
    end
    exp_sel  = op[0];
    exp_addr = AW'(nfull);
    compare(tag);
  endtask

  task automatic do_run(input string tag, input int n_over, input bit coincide, input int extra);
    int t0, t1;
    send({2'b10, 6'($urandom)});
    t0 = cyc;
    for (int i = 0; i < n_over; i++) begin
      tick(int'($urandom_range(0, 2)));
      send(8'($urandom));
      exp_err.push_back(2'(ERR_OVERRUN));
    end
    tick(extra);
    t1 = cyc;
    bus.core_done = 1'b1;
    if (coincide) begin
      bus.rx_valid = 1'b1;
      exp_err.push_back(2'(ERR_OVERRUN));
    end
    tick(1);
    bus.core_done = 1'b0;
    bus.rx_valid  = 1'b0;
    exp_start = 1;
    exp_busy  = t1 - t0 + 1;
    compare(tag);
  endtask

  task automatic do_bad(input string tag, input bit stray_core_done);
    send({2'b11, 6'($urandom)});
    if (stray_core_done) begin
      bus.core_done = 1'b1;
      tick(1);
      bus.core_done = 1'b0;
    end
    exp_err.push_back(2'(ERR_OPCODE));
    exp_busy = 0;
    compare(tag);
  endtask

  initial begin
    int kind, cnt, nsend;
    bus.rx_byte   = '0;
    bus.rx_valid  = 1'b0;
    bus.core_done = 1'b0;
    #1 rst = 1'b0;
    #20;
    check_eq("reset wr_en", 64'(bus.wr_en), 64'(0));
    check_eq("reset busy", 64'(bus.busy), 64'(0));
    check_eq("reset start/err/done", 64'({bus.start, bus.err, bus.frame_done}), 64'(0));
    check_eq("reset err_code", 64'(bus.err_code), 64'(0));
    check_eq("reset wr_addr/sel", 64'({bus.wr_addr, bus.wr_sel}), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    tick(2);

    // Directed frames from the test plan.
    pay_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'hF0};
    do_load("ldw2", 2'b00, 1, 16, 1'b0);
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_load("ldi1", 2'b01, 0, 8, 1'b0);
    do_run("run20", 0, 1'b0, 20);
    do_bad("badop", 1'b0);
    fill_rand(8);
    do_load("tmo3", 2'b00, 0, 3, 1'b0);
    do_load("after_tmo", 2'b00, 0, 8, 1'b0);
    do_run("overrun", 1, 1'b0, 3);
    fill_rand(512);
    do_load("full64", 2'b01, 63, 512, 1'b0);

    // Reset in the middle of a payload: outputs clear at once and nothing is written.
    fill_rand(8);
    send(8'h05);
    for (int i = 0; i < 5; i++) send(pay_q[i]);
    #2 rst = 1'b0;
    #1;
    check_eq("midreset outputs",
             64'({bus.wr_en, bus.busy, bus.start, bus.err, bus.frame_done, bus.wr_sel}), 64'(0));
    check_eq("midreset wr_data", bus.wr_data, 64'(0));
    check_eq("midreset err_code/addr", 64'({bus.err_code, bus.wr_addr}), 64'(0));
    tick(2);
    rst = 1'b1;
    last_data = '0;
    last_err  = '0;
    exp_addr  = '0;
    exp_sel   = 1'b0;
    compare("midreset");

    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 5));
      case (kind)
        0, 1, 5: begin
          cnt = ($urandom_range(0, 9) == 0) ? 63 : int'($urandom_range(0, 3));
          fill_rand(8 * (cnt + 1));
          do_load($sformatf("rnd%0d load", it), 2'($urandom_range(0, 1)), cnt, 8 * (cnt + 1),
                  kind == 5);
        end
        2: begin
          cnt   = int'($urandom_range(0, 3));
          nsend = int'($urandom_range(0, 8 * (cnt + 1) - 1));
          fill_rand(8 * (cnt + 1));
          do_load($sformatf("rnd%0d partial", it), 2'($urandom_range(0, 1)), cnt, nsend, 1'b1);
        end
        3: do_run($sformatf("rnd%0d run", it), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 10)));
        default: do_bad($sformatf("rnd%0d bad", it), 1'($urandom_range(0, 1)));
      endcase
    end

    check_eq("onehot wr_en/start/err", 64'(onehot_bad), 64'(0));
    check_eq("frame_done without wr_en", 64'(stray_done), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
